// File: rtl/ifetch_pkg.sv
// Shared constants for the pu instruction fetch stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: instruction width, NOP/HALT encodings, fetch FSM state encoding,
// counter width for queue/outstanding/drop bookkeeping (covers DEPTH up to 4).
package ifetch_pkg;

    localparam int CMDS = 16;

    localparam logic [CMDS-1:0] INSN_NOP  = 16'h0000;
    localparam logic [CMDS-1:0] INSN_HALT = 16'h0001;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // Wide enough to hold 0..4 for outstanding and drop counts.
    localparam int CNTW = 3;

endpackage

// File: rtl/ifetch_ifq.sv
// Prefetch queue: synchronous shift FIFO, DEPTH x W, with push/pop/flush.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: none internally; the caller guarantees no push when full.
// Ports: clk, rst (async, active-high), push/pop/flush controls, din,
//        dout (head entry), cnt (entries held).
module ifq #(
    parameter int DEPTH = 2,
    parameter int W     = 24,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  nxt [DEPTH];
    // One zero slot past the end so the shift loop never indexes out of range.
    logic [W-1:0]  ext [DEPTH+1];
    logic [CW-1:0] widx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ext[i] = mem[i];
        end
        ext[DEPTH] = '0;
        // With a simultaneous pop the entries shift down first, so the new
        // word lands one slot lower.
        widx = pop ? (cnt - CW'(1)) : cnt;
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = pop ? ext[i+1] : mem[i];
            if (push && (widx == CW'(i))) begin
                nxt[i] = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mem <= '{default: '0};
        end else if (flush) begin
            cnt <= '0;
        end else begin
            mem <= nxt;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[0];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC generation, memory request/response, prefetch queue to decoder.
// Latency: a response returned at edge N is presented on o/ovalid right after edge N.
// Backpressure: ireq drops once queued+outstanding reaches the cap; adv=0 holds the head.
// Ports: clk, rst (async, active-high); decoder side adv, h, pcwe, npc, o, ovalid, opc,
//        halted; memory side ireq, iaddr, igrant, irvalid, irdata.
// Build option IFETCH_PREFETCH_EN: when defined the queue has DEPTH entries and up to
// DEPTH requests may be outstanding; otherwise one entry and one outstanding request.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int             AW       = 8,
    parameter int             DEPTH    = 2,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            h,
    input  logic            pcwe,
    input  logic [AW-1:0]   npc,
    output logic            ireq,
    output logic [AW-1:0]   iaddr,
    input  logic            igrant,
    input  logic            irvalid,
    input  logic [CMDS-1:0] irdata,
    output logic [CMDS-1:0] o,
    output logic            ovalid,
    output logic [AW-1:0]   opc,
    output logic            halted
);

`ifdef IFETCH_PREFETCH_EN
    localparam int QD = DEPTH;
`else
    localparam int QD = 1;
`endif
    localparam int QCW = $clog2(QD + 1);
    localparam int QW  = CMDS + AW;

    logic [0:0]      state;
    logic [AW-1:0]   fpc;      // next fetch address
    logic [AW-1:0]   rpc;      // address of the next non-dropped response
    logic [CNTW-1:0] outst;
    logic [CNTW-1:0] drop;
    logic [CNTW-1:0] outst_nxt;

    logic [QCW-1:0]  q_cnt;
    logic [QW-1:0]   q_dout;
    logic [QW-1:0]   q_din;
    logic [3:0]      inflight;

    logic run, grant, redir, halt_go, pop, push;

    assign run      = (state == ST_RUN);
    assign inflight = 4'(q_cnt) + 4'(outst);
    assign ireq     = !rst && run && (inflight < 4'(QD));
    assign iaddr    = fpc;
    assign grant    = ireq && igrant;
    assign ovalid   = (q_cnt != '0);

    // pcwe outranks halt, pop and push; everything is frozen once halted.
    assign redir    = run && pcwe;
    assign halt_go  = run && ovalid && h && !pcwe;
    assign pop      = run && ovalid && adv && !h && !pcwe;
    assign push     = run && !pcwe && irvalid && (drop == '0);

    assign outst_nxt = outst + CNTW'(grant) - CNTW'(irvalid);
    assign q_din     = {rpc, irdata};

    ifq #(
        .DEPTH (QD),
        .W     (QW),
        .CW    (QCW)
    ) u_ifq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (q_din),
        .dout  (q_dout),
        .cnt   (q_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
            outst <= '0;
            drop  <= '0;
        end else begin
            outst <= outst_nxt;
            if (redir) begin
                // Every request still in flight after this edge, including one
                // granted right now, belongs to the old stream.
                drop  <= outst_nxt;
                fpc   <= npc;
                rpc   <= npc;
            end else begin
                if (irvalid && (drop != '0)) begin
                    drop <= drop - CNTW'(1);
                end
                if (grant) begin
                    fpc <= fpc + AW'(1);
                end
                if (push) begin
                    rpc <= rpc + AW'(1);
                end
                if (halt_go) begin
                    state <= ST_HALTED;
                end
            end
        end
    end

    assign o      = ovalid ? q_dout[CMDS-1:0] : INSN_NOP;
    assign opc    = ovalid ? q_dout[QW-1:CMDS] : '0;
    assign halted = (state == ST_HALTED);

endmodule
